// File: rtl/hamming_pkg.sv
// Shared constants, state encoding and encode helpers for the Hamming(7,4) pass sequencer.
// Codeword bit i-1 holds Hamming position i; data nibble bit k holds d_k.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;
  localparam int STEP_W = 3;
  localparam int T_W    = 8;

  typedef enum logic [STEP_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ENC  = 3'd2,
    ST_INJ  = 3'd3,
    ST_SYN  = 3'd4,
    ST_COR  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Data-nibble masks selecting the data bits covered by each parity bit.
  localparam logic [DATA_W-1:0] PAR_MASK_P1 = 4'b1011;  // d0,d1,d3
  localparam logic [DATA_W-1:0] PAR_MASK_P2 = 4'b1101;  // d0,d2,d3
  localparam logic [DATA_W-1:0] PAR_MASK_P4 = 4'b1110;  // d1,d2,d3

  // Codeword masks selecting the positions checked by each syndrome bit.
  localparam logic [CODE_W-1:0] SYN_MASK_S1 = 7'b1010101;  // positions 1,3,5,7
  localparam logic [CODE_W-1:0] SYN_MASK_S2 = 7'b1100110;  // positions 2,3,6,7
  localparam logic [CODE_W-1:0] SYN_MASK_S4 = 7'b1111000;  // positions 4,5,6,7

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic p1;
    logic p2;
    logic p4;
    p1 = ^(d & PAR_MASK_P1);
    p2 = ^(d & PAR_MASK_P2);
    p4 = ^(d & PAR_MASK_P4);
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Single-bit mask for a Hamming position; position 0 yields no flip.
  function automatic logic [CODE_W-1:0] pos_mask(input logic [SYN_W-1:0] pos);
    logic [CODE_W-1:0] m;
    m = '0;
    if (pos != '0) begin
      m = 7'(1) << (pos - 3'd1);
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) syndrome: {s4,s2,s1}, which equals the erroneous position
// for any single-bit error and zero for a valid codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn
);

  assign syn = {^(code & SYN_MASK_S4), ^(code & SYN_MASK_S2), ^(code & SYN_MASK_S1)};

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Sequenced encode / error-inject / syndrome / correct pass over one nibble.
// Seven-state FSM; results are registered and held from DONE until the next LOAD.
module hamming_seq_ctrl
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_en,
  input  logic [SYN_W-1:0]  err_pos,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step,
  output logic [T_W-1:0]    T,
  output logic [CODE_W-1:0] code_out,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err_detected,
  output logic [DATA_W-1:0] data_out
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_en_q, err_en_d;
  logic [SYN_W-1:0]    err_pos_q, err_pos_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [SYN_W-1:0]    syn_q, syn_d;
  logic                err_det_q, err_det_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic [SYN_W-1:0]    syn_calc;
  logic [CODE_W-1:0]   corrected;

  hamming_syndrome u_syndrome (
    .code (code_q),
    .syn  (syn_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      code_q    <= '0;
      syn_q     <= '0;
      err_det_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      err_en_q  <= err_en_d;
      err_pos_q <= err_pos_d;
      code_q    <= code_d;
      syn_q     <= syn_d;
      err_det_q <= err_det_d;
      dout_q    <= dout_d;
    end
  end

  // Start is only looked at in IDLE, so a request during a pass is dropped, not queued.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_ENC;
      ST_ENC:  state_d = ST_INJ;
      ST_INJ:  state_d = ST_SYN;
      ST_SYN:  state_d = ST_COR;
      ST_COR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    err_en_d  = err_en_q;
    err_pos_d = err_pos_q;
    code_d    = code_q;
    syn_d     = syn_q;
    err_det_d = err_det_q;
    dout_d    = dout_q;
    corrected = code_q ^ pos_mask(syn_q);
    case (state_q)
      ST_LOAD: begin
        data_d    = data_in;
        err_en_d  = err_en;
        err_pos_d = err_pos;
      end
      ST_ENC: code_d = hamming_encode(data_q);
      ST_INJ: begin
        if (err_en_q) begin
          code_d = code_q ^ pos_mask(err_pos_q);
        end
      end
      ST_SYN: begin
        syn_d     = syn_calc;
        err_det_d = (syn_calc != '0);
      end
      ST_COR: dout_d = extract_data(corrected);
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    step         = state_q;
    T            = '0;
    T[state_q]   = 1'b1;
    code_out     = code_q;
    syndrome     = syn_q;
    err_detected = err_det_q;
    data_out     = dout_q;
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Self-checking bench: a cycle-age pass model plus positional Hamming arithmetic,
// compared every cycle, with literal vectors and a full data x position sweep.
module tb_hamming_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] data_in;
  logic       err_en;
  logic [2:0] err_pos;
  logic       busy;
  logic       done;
  logic [2:0] step;
  logic [7:0] T;
  logic [6:0] code_out;
  logic [2:0] syndrome;
  logic       err_detected;
  logic [3:0] data_out;

  int checks = 0;
  int errors = 0;

  hamming_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .err_en       (err_en),
    .err_pos      (err_pos),
    .busy         (busy),
    .done         (done),
    .step         (step),
    .T            (T),
    .code_out     (code_out),
    .syndrome     (syndrome),
    .err_detected (err_detected),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: positions 3,5,6,7 carry data, parity position k covers
  // every other position whose index has bit k set.
  function automatic logic [6:0] m_encode(input logic [3:0] d);
    logic [6:0] c;
    logic       p;
    c = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    for (int k = 1; k <= 4; k = k * 2) begin
      p = 1'b0;
      for (int j = 1; j <= 7; j++) begin
        if (((j & k) != 0) && (j != k)) p = p ^ c[j-1];
      end
      c[k-1] = p;
    end
    return c;
  endfunction

  // Syndrome as the XOR of the indices of all set positions.
  function automatic logic [2:0] m_syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int j = 1; j <= 7; j++) begin
      if (c[j-1]) s = s ^ j;
    end
    return 3'(s);
  endfunction

  int         m_age;
  logic [3:0] m_d;
  logic       m_en;
  logic [2:0] m_pos;
  logic [6:0] m_code;
  logic [2:0] m_syn;
  logic       m_det;
  logic [3:0] m_dout;

  initial begin
    m_age = 0; m_d = '0; m_en = 1'b0; m_pos = '0;
    m_code = '0; m_syn = '0; m_det = 1'b0; m_dout = '0;
  end

  // m_age: 0 when idle, otherwise cycles elapsed since the start-sampling edge.
  always @(posedge clk) begin
    logic [6:0] rx;
    logic [2:0] s;
    if (rst) begin
      m_age = 0; m_d = '0; m_en = 1'b0; m_pos = '0;
      m_code = '0; m_syn = '0; m_det = 1'b0; m_dout = '0;
    end else begin
      case (m_age)
        0: if (start) m_age = 1;
        1: begin
          m_d = data_in; m_en = err_en; m_pos = err_pos;
          m_age = 2;
        end
        5: begin
          rx = m_encode(m_d);
          if (m_en && m_pos != 0) rx[m_pos-1] = ~rx[m_pos-1];
          s = m_syndrome(rx);
          m_code = rx;
          m_syn  = s;
          m_det  = (s != 0);
          if (s != 0) rx[s-1] = ~rx[s-1];
          m_dout = {rx[6], rx[5], rx[4], rx[2]};
          m_age = 6;
        end
        6: m_age = 0;
        default: m_age = m_age + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("step", 32'(step), 32'(m_age));
    chk("T", 32'(T), 32'(8'(1) << m_age));
    chk("T_onehot", 32'($onehot(T)), 32'd1);
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("done", 32'(done), 32'(m_age == 6));
    if (m_age == 0 || m_age == 6) begin
      chk("code_out", 32'(code_out), 32'(m_code));
      chk("syndrome", 32'(syndrome), 32'(m_syn));
      chk("err_detected", 32'(err_detected), 32'(m_det));
      chk("data_out", 32'(data_out), 32'(m_dout));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issues one pass, scrambles the inputs once LOAD has consumed them, and returns at
  // the DONE cycle with the number of cycles elapsed since the start-sampling edge.
  task automatic run_pass(input logic [3:0] d, input logic en, input logic [2:0] pos,
                          output int lat);
    wait_idle();
    start = 1'b1; data_in = d; err_en = en; err_pos = pos;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        data_in = 4'($urandom);
        err_en  = 1'($urandom);
        err_pos = 3'($urandom);
      end
    end
  endtask

  initial begin
    int lat;
    int dones;
    rst = 1'b1; start = 1'b1; data_in = 4'b0110; err_en = 1'b0; err_pos = '0;
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_T", 32'(T), 32'h01);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({code_out, syndrome, err_detected, data_out}), 32'd0);

    // start held across reset release is taken on the very next edge
    rst = 1'b0;
    @(negedge clk);
    chk("start_after_rst", 32'(step), 32'd1);
    start = 1'b0;
    wait_idle();

    run_pass(4'b1011, 1'b0, 3'd0, lat);
    chk("lat_1011", 32'(lat), 32'd6);
    chk("code_1011", 32'(code_out), 32'b1010101);
    chk("syn_1011", 32'(syndrome), 32'd0);
    chk("det_1011", 32'(err_detected), 32'd0);
    chk("dout_1011", 32'(data_out), 32'b1011);
    @(negedge clk);
    chk("hold_idle_step", 32'(step), 32'd0);
    chk("hold_idle_code", 32'(code_out), 32'b1010101);

    run_pass(4'b1011, 1'b1, 3'd5, lat);
    chk("code_1011_p5", 32'(code_out), 32'b1000101);
    chk("syn_1011_p5", 32'(syndrome), 32'd5);
    chk("det_1011_p5", 32'(err_detected), 32'd1);
    chk("dout_1011_p5", 32'(data_out), 32'b1011);

    run_pass(4'b0000, 1'b1, 3'd3, lat);
    chk("code_0000_p3", 32'(code_out), 32'b0000100);
    chk("syn_0000_p3", 32'(syndrome), 32'd3);
    chk("dout_0000_p3", 32'(data_out), 32'd0);

    run_pass(4'b0101, 1'b1, 3'd0, lat);
    chk("syn_pos0", 32'(syndrome), 32'd0);
    chk("det_pos0", 32'(err_detected), 32'd0);

    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        run_pass(4'(d), 1'b1, 3'(p), lat);
        chk("sweep_dout", 32'(data_out), 32'(d));
        chk("sweep_lat", 32'(lat), 32'd6);
      end
    end

    // reset during SYN
    wait_idle();
    start = 1'b1; data_in = 4'b1111; err_en = 1'b1; err_pos = 3'd6;
    repeat (4) @(negedge clk);
    start = 1'b0;
    chk("in_syn", 32'(step), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_T", 32'(T), 32'h01);
    chk("midrst_outs", 32'({busy, done, code_out, syndrome, err_detected, data_out}), 32'd0);

    // start pulsed during ENC is dropped
    wait_idle();
    start = 1'b1; data_in = 4'b1001; err_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("enc_start_dones", 32'(dones), 32'd1);

    // start held through DONE gets exactly one IDLE cycle before the next LOAD
    wait_idle();
    start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("held_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("held_idle", 32'(step), 32'd0);
    @(negedge clk);
    chk("held_reload", 32'(step), 32'd1);
    start = 1'b0;

    // random traffic including occasional resets; the per-cycle compare does the checking
    repeat (600) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 3) == 0);
      data_in = 4'($urandom);
      err_en  = 1'($urandom);
      err_pos = 3'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
